cmp_ge_serial: RTL
==================

// Module: cmp_ge_serial
// PURPOSE
//  Digit-serial, multi-mode magnitude comparator with valid/ready handshakes on both sides.
//  Compares WIDTH-bit operands DIGIT bits per cycle, LSB digit first.
//  Uses a running generate/propagate carry: per digit, g = G_d | (P_d & g).
//  Signed or unsigned mode; six relational ops.
//  Sits beside the combinational comparators, for wide operands where area beats latency.
// PARAMETERS
//  WIDTH      32  operand width in bits, >=2
//  DIGIT       8  bits processed per cycle, 1..WIDTH
//  ND         ceil(WIDTH/DIGIT)  localparam, number of digits/compute cycles
//  CNT_W      $clog2(ND+1)       localparam, digit-counter width
// PORTS
//  clk_i        in   1      clock, all state on rising edge
//  rst_ni       in   1      reset, synchronous, active-low
//  in_valid_i   in   1      request valid
//  in_ready_o   out  1      request accepted when in_valid_i & in_ready_o
//  a_i          in   WIDTH  operand A
//  b_i          in   WIDTH  operand B
//  signed_i     in   1      1: two's-complement compare, 0: unsigned
//  op_i         in   3      cmp_op_e: GE=0 GT=1 LE=2 LT=3 EQ=4 NE=5 (6,7 -> res 0)
//  out_valid_o  out  1      result valid, held until taken
//  out_ready_i  in   1      result consumed when out_valid_o & out_ready_i
//  res_o        out  1      op-selected result
//  ge_o         out  1      A >= B, in the selected signedness
//  eq_o         out  1      A == B
// BEHAVIOUR
//  Reset (rst_ni=0 at an edge): state IDLE, counter 0.
//   Outputs after reset: out_valid_o=0, res_o=0, ge_o=0, eq_o=0, in_ready_o=1.
//   Reset mid-RUN or in DONE discards the operation; no result is emitted.
//  FSM states: IDLE, RUN, DONE.
//   IDLE -> RUN on request handshake.
//   RUN  -> DONE after the ND-th digit.
//   DONE -> IDLE when output is taken and no new request is accepted.
//   DONE -> RUN when output is taken and a new request is accepted in the same cycle.
//  in_ready_o = (state==IDLE) | (state==DONE & out_ready_i). Combinational from out_ready_i only.
//  On accept:
//   Latch op and signedness.
//   Form a' = a_i with bit WIDTH-1 inverted when signed_i=1, else a_i; b' likewise.
//   Zero-extend a' and b' to ND*DIGIT and load the A/B shift registers.
//   Set g=1 (GE seed), e=1, counter=0.
//  RUN, each cycle:
//   d_a, d_b = low DIGIT bits of the shift registers.
//   G_d = (d_a > d_b); P_d = (d_a == d_b).
//   g <= G_d | (P_d & g); e <= e & P_d.
//   Shift A and B right by DIGIT; counter++.
//   After the edge where counter reaches ND, go to DONE.
//  Latency: accept at edge t -> out_valid_o=1 after edge t+ND.
//   Throughput is one result per ND+1 cycles with out_ready_i held high; no bubble beyond that.
//  In DONE, outputs:
//   ge_o=g, eq_o=e.
//   res_o by op: GE=g, GT=g&~e, LE=~g|e, LT=~g, EQ=e, NE=~e.
//   ge_o, eq_o, res_o are registered (or decoded from registers) and stable while out_valid_o=1.
//   Outside DONE, res_o, ge_o and eq_o are 0.
//  Backpressure: out_ready_i=0 holds DONE and all outputs indefinitely.
//  Inputs a_i, b_i, op_i, signed_i are sampled only at accept; changes at other times have no effect.
//  DIGIT=WIDTH gives ND=1: single compute cycle, same FSM.
// STRUCTURE
//  cmp_pkg holds:
//   typedef enum logic [2:0] cmp_op_e (values above).
//   typedef enum logic [1:0] cmp_state_e {IDLE, RUN, DONE}.
//   function cmp_res(op, g, e) implementing the op decode.
//  One sub-module, cmp_ge_digit (parameter DIGIT):
//   combinational per-digit G_d/P_d generation and the carry merge.
//   ports: d_a, d_b, g_in, e_in -> g_out, e_out.
//  Top: handshake, FSM, counter, shift registers, result registers.
// TESTING
//  Checker: behavioural reference model, per-op and signedness.
//  Any accepted transaction yielding a result after reset or flush is a failure.
//  1. WIDTH=32, DIGIT=8, unsigned GE: A=0x0000_0100, B=0x0000_00FF.
//     Expect res=1 ge=1 eq=0, out_valid_o exactly 4 cycles after accept.
//  2. Signed LT: A=0x8000_0000, B=0x0000_0001 -> res=1.
//     Same operands unsigned LT -> res=0.
//  3. EQ/NE/GT with A=B=0xDEAD_BEEF:
//     EQ=1, NE=0, GT=0; GE and LE = 1.
//  4. Backpressure: out_ready_i=0 for 10 cycles in DONE.
//     Outputs stable, in_ready_o=0. Then release with a new in_valid_i in the same cycle:
//     back-to-back accept, next result ND+1 cycles later.
//  5. Reset mid-RUN: drop rst_ni at counter=2, then hold rst_ni high.
//     out_valid_o stays 0, in_ready_o=1; the next request completes normally.
//  6. Odd geometry: WIDTH=13, DIGIT=4 (ND=4, zero padding).
//     10k random signed/unsigned ops vs behavioural model; all match.

Source files
------------

// File: rtl/cmp_ge_serial_pkg.sv
// Shared types and op decode for the digit-serial magnitude comparator.
package cmp_ge_serial_pkg;

  typedef enum logic [2:0] {
    OP_GE = 3'd0,
    OP_GT = 3'd1,
    OP_LE = 3'd2,
    OP_LT = 3'd3,
    OP_EQ = 3'd4,
    OP_NE = 3'd5
  } cmp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  // Codes 6 and 7 are not ops and always resolve to 0.
  function automatic logic cmp_res(input logic [2:0] op, input logic g, input logic e);
    logic r;
    r = 1'b0;
    case (op)
      OP_GE:   r = g;
      OP_GT:   r = g & ~e;
      OP_LE:   r = ~g | e;
      OP_LT:   r = ~g;
      OP_EQ:   r = e;
      OP_NE:   r = ~e;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_ge_serial_if.sv
// Request/result handshake bundle between a requester and cmp_ge_serial.
interface cmp_ge_serial_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             signed_i;
  logic [2:0]       op_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             res_o;
  logic             ge_o;
  logic             eq_o;

  modport master (
    output in_valid_i, a_i, b_i, signed_i, op_i, out_ready_i,
    input  in_ready_o, out_valid_o, res_o, ge_o, eq_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, signed_i, op_i, out_ready_i,
    output in_ready_o, out_valid_o, res_o, ge_o, eq_o
  );
endinterface

// File: rtl/cmp_ge_serial_digit.sv
// One digit of the running compare: local generate/propagate merged into the carry.
module cmp_ge_digit #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] d_a_i,
  input  logic [DIGIT-1:0] d_b_i,
  input  logic             g_i,
  input  logic             e_i,
  output logic             g_o,
  output logic             e_o
);
  logic gen;
  logic prop;

  assign gen  = (d_a_i > d_b_i);
  assign prop = (d_a_i == d_b_i);
  // A higher digit decides on its own unless equal, then the lower result carries through.
  assign g_o  = gen | (prop & g_i);
  assign e_o  = e_i & prop;
endmodule

// File: rtl/cmp_ge_serial.sv
// Digit-serial A>=B / A==B comparator, LSB digit first, with six relational ops.
module cmp_ge_serial
  import cmp_ge_serial_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input logic           clk_i,
  input logic           rst_ni,
  cmp_ge_serial_if.slave bus
);
  localparam int ND    = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int CNT_W = $clog2(ND + 1);
  localparam int PW    = ND * DIGIT;

  cmp_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    a_q, a_d, b_q, b_d;
  logic             g_q, g_d, e_q, e_d;
  logic [2:0]       op_q, op_d;
  logic             g_nxt, e_nxt;
  logic             accept;
  logic             done;
  logic [WIDTH-1:0] a_mod, b_mod;
  logic [WIDTH-1:0] sign_flip;

  assign bus.in_ready_o = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready_i);
  assign accept         = bus.in_valid_i & bus.in_ready_o;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign sign_flip = {bus.signed_i, {(WIDTH-1){1'b0}}};
  assign a_mod     = bus.a_i ^ sign_flip;
  assign b_mod     = bus.b_i ^ sign_flip;

  cmp_ge_digit #(.DIGIT(DIGIT)) u_digit (
    .d_a_i (a_q[DIGIT-1:0]),
    .d_b_i (b_q[DIGIT-1:0]),
    .g_i   (g_q),
    .e_i   (e_q),
    .g_o   (g_nxt),
    .e_o   (e_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    g_d     = g_q;
    e_d     = e_q;
    op_d    = op_q;
    case (state_q)
      IDLE: ;
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        g_d   = g_nxt;
        e_d   = e_nxt;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ND - 1)) state_d = DONE;
      end
      DONE: if (bus.out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Accept is only possible in IDLE or DONE, so it overrides those transitions.
    if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      a_d     = PW'(a_mod);
      b_d     = PW'(b_mod);
      g_d     = 1'b1;
      e_d     = 1'b1;
      op_d    = bus.op_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= 1'b0;
      e_q     <= 1'b0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      g_q     <= g_d;
      e_q     <= e_d;
      op_q    <= op_d;
    end
  end

  assign done            = (state_q == DONE);
  assign bus.out_valid_o = done;
  assign bus.ge_o        = done & g_q;
  assign bus.eq_o        = done & e_q;
  assign bus.res_o       = done & cmp_res(op_q, g_q, e_q);
endmodule
